// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions and
// the multiply sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    // flags port is {N,V,C,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nbit_adder.sv
// Ripple-style WIDTH-bit adder with carry-in, carry-out and signed overflow;
// shared by the add/subtract ops and the multiply accumulate step.
module nbit_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH:0] total_s;

    assign total_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum      = total_s[WIDTH-1:0];
    assign cout     = total_s[WIDTH];
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/sequential_alu.sv
// Registered ALU: single-cycle arithmetic/logic ops plus a WIDTH-iteration
// shift-add unsigned multiplier sequenced by a small FSM.
module sequential_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               out_en,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   result_hi,
    output logic [3:0]         flags,
    output logic [WIDTH-1:0]   bus_out
);

    state_t              state_r;
    logic [WIDTH-1:0]    mcand_r;
    logic [2*WIDTH-1:0]  prod_r;
    logic [5:0]          count_r;
    logic [WIDTH-1:0]    result_r;
    logic [WIDTH-1:0]    result_hi_r;
    logic [3:0]          flags_r;
    logic                done_r;
    logic                busy_r;

    logic [WIDTH-1:0]    add_a_s;
    logic [WIDTH-1:0]    add_b_s;
    logic                add_cin_s;
    logic [WIDTH-1:0]    add_sum_s;
    logic                add_cout_s;
    logic                add_ovf_s;

    logic [WIDTH-1:0]    alu_res_s;
    logic                alu_c_s;
    logic                alu_v_s;
    logic                op_valid_s;
    logic [3:0]          alu_flags_s;
    logic [2*WIDTH-1:0]  mul_next_s;
    logic [3:0]          mul_flags_s;

    // Adder operand select: multiplier accumulate while BUSY, else the requested add/sub
    always_comb begin
        add_a_s   = a;
        add_b_s   = b;
        add_cin_s = 1'b0;
        if (state_r == ST_BUSY) begin
            add_a_s   = prod_r[2*WIDTH-1:WIDTH];
            add_b_s   = mcand_r;
            add_cin_s = 1'b0;
        end else begin
            case (op)
                OP_SUB: begin
                    add_b_s   = ~b;
                    add_cin_s = 1'b1;
                end
                OP_ADC: add_cin_s = flags_r[FLAG_C];
                OP_SBC: begin
                    add_b_s   = ~b;
                    add_cin_s = flags_r[FLAG_C];
                end
                default: add_cin_s = 1'b0;
            endcase
        end
    end

    nbit_adder #(.WIDTH(WIDTH)) u_adder (
        .a        (add_a_s),
        .b        (add_b_s),
        .cin      (add_cin_s),
        .sum      (add_sum_s),
        .cout     (add_cout_s),
        .overflow (add_ovf_s)
    );

    // Single-cycle op result and flags
    always_comb begin
        alu_res_s  = {WIDTH{1'b0}};
        alu_c_s    = 1'b0;
        alu_v_s    = 1'b0;
        op_valid_s = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                alu_res_s = add_sum_s;
                alu_c_s   = add_cout_s;
                alu_v_s   = add_ovf_s;
            end
            OP_AND: alu_res_s = a & b;
            OP_OR:  alu_res_s = a | b;
            OP_XOR: alu_res_s = a ^ b;
            OP_NOT: alu_res_s = ~a;
            OP_SHL: begin
                alu_res_s = {a[WIDTH-2:0], 1'b0};
                alu_c_s   = a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res_s = {1'b0, a[WIDTH-1:1]};
                alu_c_s   = a[0];
            end
            default: op_valid_s = 1'b0;
        endcase
        alu_flags_s         = 4'b0000;
        alu_flags_s[FLAG_N] = alu_res_s[WIDTH-1];
        alu_flags_s[FLAG_V] = alu_v_s;
        alu_flags_s[FLAG_C] = alu_c_s;
        alu_flags_s[FLAG_Z] = (alu_res_s == {WIDTH{1'b0}});
    end

    // One shift-add step: conditionally add multiplicand into the high half, then shift right
    always_comb begin
        if (prod_r[0]) begin
            mul_next_s = {add_cout_s, add_sum_s, prod_r[WIDTH-1:1]};
        end else begin
            mul_next_s = {1'b0, prod_r[2*WIDTH-1:1]};
        end
        mul_flags_s         = 4'b0000;
        mul_flags_s[FLAG_N] = mul_next_s[WIDTH-1];
        mul_flags_s[FLAG_C] = (mul_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
        mul_flags_s[FLAG_V] = mul_flags_s[FLAG_C];
        mul_flags_s[FLAG_Z] = (mul_next_s == {(2*WIDTH){1'b0}});
    end

    // Control FSM and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            mcand_r     <= {WIDTH{1'b0}};
            prod_r      <= {(2*WIDTH){1'b0}};
            count_r     <= 6'd0;
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            flags_r     <= 4'b0000;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                // DONE only marks the pulse; it accepts a new request exactly like IDLE
                ST_IDLE, ST_DONE: begin
                    state_r <= ST_IDLE;
                    if (start) begin
                        if (op == OP_MUL) begin
                            state_r <= ST_BUSY;
                            busy_r  <= 1'b1;
                            mcand_r <= a;
                            prod_r  <= {{WIDTH{1'b0}}, b};
                            count_r <= 6'd0;
                        end else begin
                            done_r <= 1'b1;
                            if (op_valid_s) begin
                                result_r    <= alu_res_s;
                                result_hi_r <= {WIDTH{1'b0}};
                                flags_r     <= alu_flags_s;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    prod_r  <= mul_next_s;
                    count_r <= count_r + 6'd1;
                    if (count_r == 6'(WIDTH - 1)) begin
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        result_r    <= mul_next_s[WIDTH-1:0];
                        result_hi_r <= mul_next_s[2*WIDTH-1:WIDTH];
                        flags_r     <= mul_flags_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign flags     = flags_r;
    assign bus_out   = out_en ? result_r : {WIDTH{1'b0}};

endmodule

// File: tb/tb_sequential_alu.sv
// Self-checking bench for sequential_alu: directed corner cases plus random
// ops compared against an arithmetic reference model.
module tb_sequential_alu;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_en;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic [3:0]    flags;
    logic [W-1:0]  bus_out;

    int tests = 0;
    int fails = 0;
    int lat;
    int m_res;
    int m_hi;
    logic [3:0] m_flags;

    sequential_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_en    (out_en),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .bus_out   (bus_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    // Reference: updates the architectural state {result, result_hi, N V C Z}
    task automatic model_apply(input int o, input int ai, input int bi);
        int mask;
        int cin;
        int s;
        int sr;
        int res;
        int hi;
        longint p;
        bit c;
        bit v;
        bit z;
        mask = (1 << W) - 1;
        hi = 0; c = 1'b0; v = 1'b0; res = 0; p = 0;
        case (o)
            0, 2: begin
                cin = (o == 2) ? int'(m_flags[1]) : 0;
                s   = ai + bi + cin;
                sr  = sx(ai) + sx(bi) + cin;
                res = s & mask;
                c   = ((s >> W) & 1) != 0;
                v   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
            end
            1, 3: begin
                cin = (o == 1) ? 1 : int'(m_flags[1]);
                s   = ai + (mask - bi) + cin;
                sr  = sx(ai) - sx(bi) - (1 - cin);
                res = s & mask;
                c   = ((s >> W) & 1) != 0;
                v   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
            end
            4: res = ai & bi;
            5: res = ai | bi;
            6: res = ai ^ bi;
            7: res = (~ai) & mask;
            8: begin
                res = (ai << 1) & mask;
                c   = ((ai >> (W - 1)) & 1) != 0;
            end
            9: begin
                res = ai >> 1;
                c   = (ai & 1) != 0;
            end
            10: begin
                p   = longint'(ai) * longint'(bi);
                res = int'(p & longint'(mask));
                hi  = int'(p >> W);
                c   = (hi != 0);
                v   = c;
            end
            default: return;
        endcase
        z = (o == 10) ? (p == 0) : (res == 0);
        m_res   = res;
        m_hi    = hi;
        m_flags = {((res >> (W - 1)) & 1) != 0, v, c, z};
    endtask

    // Present a request; with now=1 it is driven in the current cycle
    task automatic issue(input bit now, input int o, input int ai, input int bi);
        if (!now) @(negedge clk);
        start = 1'b1;
        op    = 4'(o);
        a     = W'(ai);
        b     = W'(bi);
        model_apply(o, ai, bi);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count cycles until done; optionally pulse an ADD request at cycle inj
    task automatic wait_done(input int inj, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1'b1;
            end else if (n == inj) begin
                chk("busy_mid", 64'(busy), 64'(1));
                start = 1'b1; op = 4'd0; a = 8'h01; b = 8'h01;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        if (!got) chk("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic check_res(input string tag, input int exp_lat, input int n, input bit chk_hi);
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_result"}, 64'(result), 64'(m_res));
        if (chk_hi) chk({tag, "_hi"}, 64'(result_hi), 64'(m_hi));
        chk({tag, "_flags"}, 64'(flags), 64'(m_flags));
        chk({tag, "_bus"}, 64'(bus_out), out_en ? 64'(m_res) : 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0; out_en = 1'b1;
        m_res = 0; m_hi = 0; m_flags = 4'b0000;
        #3;
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_hi", 64'(result_hi), 64'(0));
        chk("rst_flags", 64'(flags), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b0, 0, 'hFF, 'h01); wait_done(0, lat);
        check_res("add_ff_01", 1, lat, 1'b1);
        chk("add_ff_01_nvcz", 64'(flags), 64'(4'b0011));

        issue(1'b0, 1, 'h05, 'h07); wait_done(0, lat);
        check_res("sub_05_07", 1, lat, 1'b1);
        chk("sub_05_07_val", 64'(result), 64'(8'hFE));

        issue(1'b0, 1, 'h80, 'h01); wait_done(0, lat);
        check_res("sub_80_01", 1, lat, 1'b1);
        chk("sub_80_01_nvcz", 64'(flags), 64'(4'b0110));

        issue(1'b0, 0, 'hFF, 'h01); wait_done(0, lat);
        check_res("add_pre_adc", 1, lat, 1'b1);
        issue(1'b1, 2, 'h10, 'h20); wait_done(0, lat);
        check_res("adc_b2b", 1, lat, 1'b1);
        chk("adc_b2b_val", 64'(result), 64'(8'h31));

        issue(1'b0, 10, 'h0F, 'h11); wait_done(3, lat);
        check_res("mul_0f_11", W + 1, lat, 1'b1);
        chk("mul_0f_11_val", 64'(result), 64'(8'hFF));
        @(negedge clk);
        chk("mul_ignored_done", 64'(done), 64'(0));
        chk("mul_ignored_hold", 64'(result), 64'(8'hFF));

        issue(1'b0, 0, 'h2D, 'h2D); wait_done(0, lat);
        check_res("add_5a", 1, lat, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_en = i[0];
            #1 chk("bus_toggle", 64'(bus_out), i[0] ? 64'(8'h5A) : 64'(0));
        end
        out_en = 1'b1;
        issue(1'b0, 12, 'h33, 'h44); wait_done(0, lat);
        check_res("reserved_12", 1, lat, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int o;
            @(negedge clk);
            chk("hold_done", 64'(done), 64'(0));
            chk("hold_result", 64'(result), 64'(m_res));
            chk("hold_flags", 64'(flags), 64'(m_flags));
            out_en = 1'($urandom_range(0, 1));
            o = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) o = 10;
            issue(1'b1, o, $urandom_range(0, 255), $urandom_range(0, 255));
            wait_done(0, lat);
            check_res("rand", (o == 10) ? W + 1 : 1, lat, o < 11);
        end
        out_en = 1'b1;

        issue(1'b0, 0, 'h07, 'h06); wait_done(0, lat);
        check_res("add_pre_rst", 1, lat, 1'b1);
        issue(1'b0, 10, 'hFF, 'hFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mul_ff_busy", 64'(busy), 64'(1));
            chk("mul_ff_nodone", 64'(done), 64'(0));
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_result", 64'(result), 64'(0));
        chk("abort_hi", 64'(result_hi), 64'(0));
        chk("abort_flags", 64'(flags), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_bus", 64'(bus_out), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_nodone", 64'(done), 64'(0));
        end
        rst_n = 1'b1;
        m_res = 0; m_hi = 0; m_flags = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_nodone_after", 64'(done), 64'(0));
        end
        issue(1'b0, 0, 'h01, 'h02); wait_done(0, lat);
        check_res("add_after_rst", 1, lat, 1'b1);
        chk("add_after_rst_val", 64'(result), 64'(8'h03));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
